// File: rtl/sram_rw_arbiter_pkg.sv
// Shared sizing and state encoding for the two-requester SRAM arbiter.
package sram_rw_arbiter_pkg;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry synchronous response FIFO with occupancy output.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   push, push_data   : enqueue one read word
//   valid, ready, data: dequeue handshake (pop when valid & ready)
//   occ               : current number of stored entries (0..2)
module resp_fifo2
  import sram_rw_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              pop;
  logic              do_push;

  assign pop     = valid & ready;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push & ((count != 2'd2) | pop);

  // Pointer and occupancy state
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(pop);
    end
  end

  // Data storage, not reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];
  assign occ   = count;

endmodule

// File: rtl/sram_rw_arbiter.sv
// Arbitrates two read/write requesters onto one single-port SRAM, zero-fills
// the SRAM after reset and returns read data through per-requester FIFOs.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   req_n_*  (n = 0,1)     : request channel; req_n_ready is the grant
//   resp_n_* (n = 0,1)     : read-response channel
//   sram_*                 : SRAM port; sram_rdata arrives one cycle after a read
//   init_done              : zero-fill finished, requests now accepted
module sram_rw_arbiter
  import sram_rw_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_0_valid,
  output logic              req_0_ready,
  input  logic              req_0_wmode,
  input  logic [ADDR_W-1:0] req_0_addr,
  input  logic [MASK_W-1:0] req_0_wmask,
  input  logic [DATA_W-1:0] req_0_wdata,
  output logic              resp_0_valid,
  input  logic              resp_0_ready,
  output logic [DATA_W-1:0] resp_0_rdata,
  input  logic              req_1_valid,
  output logic              req_1_ready,
  input  logic              req_1_wmode,
  input  logic [ADDR_W-1:0] req_1_addr,
  input  logic [MASK_W-1:0] req_1_wmask,
  input  logic [DATA_W-1:0] req_1_wdata,
  output logic              resp_1_valid,
  input  logic              resp_1_ready,
  output logic [DATA_W-1:0] resp_1_rdata,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] counter_q, counter_d;
  logic              ptr_q, ptr_d;
  logic              inflight_0_q, inflight_0_d;
  logic              inflight_1_q, inflight_1_d;
  logic [1:0]        occ_0, occ_1;
  logic              elig_0, elig_1;

  // Reads are held back once the FIFO could not absorb another response.
  assign elig_0 = req_0_valid & (req_0_wmode | ((3'(occ_0) + 3'(inflight_0_q)) < 3'd2));
  assign elig_1 = req_1_valid & (req_1_wmode | ((3'(occ_1) + 3'(inflight_1_q)) < 3'd2));

  // State, init counter, priority pointer and in-flight read flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= INIT;
      counter_q    <= '0;
      ptr_q        <= 1'b0;
      inflight_0_q <= 1'b0;
      inflight_1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      ptr_q        <= ptr_d;
      inflight_0_q <= inflight_0_d;
      inflight_1_q <= inflight_1_d;
    end
  end

  // Next-state, arbitration and SRAM drive
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    ptr_d        = ptr_q;
    inflight_0_d = 1'b0;
    inflight_1_d = 1'b0;
    req_0_ready  = 1'b0;
    req_1_ready  = 1'b0;
    sram_en      = 1'b0;
    sram_wmode   = 1'b0;
    sram_addr    = '0;
    sram_wmask   = '0;
    sram_wdata   = '0;
    init_done    = 1'b0;

    case (state_q)
      INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_wmask = '1;
        sram_addr  = counter_q;
        counter_d  = counter_q + ADDR_W'(1);
        if (counter_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        // ptr_q names the side that wins a tie.
        if (elig_0 && (!elig_1 || !ptr_q)) begin
          req_0_ready  = 1'b1;
          sram_en      = 1'b1;
          sram_wmode   = req_0_wmode;
          sram_addr    = req_0_addr;
          sram_wmask   = req_0_wmask;
          sram_wdata   = req_0_wdata;
          inflight_0_d = ~req_0_wmode;
          ptr_d        = 1'b1;
        end else if (elig_1) begin
          req_1_ready  = 1'b1;
          sram_en      = 1'b1;
          sram_wmode   = req_1_wmode;
          sram_addr    = req_1_addr;
          sram_wmask   = req_1_wmask;
          sram_wdata   = req_1_wdata;
          inflight_1_d = ~req_1_wmode;
          ptr_d        = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // The in-flight flag marks the cycle in which sram_rdata is valid.
  resp_fifo2 u_fifo_0 (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_0_q),
    .push_data (sram_rdata),
    .valid     (resp_0_valid),
    .ready     (resp_0_ready),
    .data      (resp_0_rdata),
    .occ       (occ_0)
  );

  resp_fifo2 u_fifo_1 (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_1_q),
    .push_data (sram_rdata),
    .valid     (resp_1_valid),
    .ready     (resp_1_ready),
    .data      (resp_1_rdata),
    .occ       (occ_1)
  );

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Self-checking bench for sram_rw_arbiter: behavioural SRAM, reference model
// of grants/responses, directed scenarios and a randomized phase.
module tb_sram_rw_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_0_valid, req_0_ready, req_0_wmode;
  logic [7:0]  req_0_addr, req_0_wmask;
  logic [63:0] req_0_wdata;
  logic        resp_0_valid, resp_0_ready;
  logic [63:0] resp_0_rdata;
  logic        req_1_valid, req_1_ready, req_1_wmode;
  logic [7:0]  req_1_addr, req_1_wmask;
  logic [63:0] req_1_wdata;
  logic        resp_1_valid, resp_1_ready;
  logic [63:0] resp_1_rdata;
  logic        sram_en, sram_wmode;
  logic [7:0]  sram_addr, sram_wmask;
  logic [63:0] sram_wdata, sram_rdata;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sram_rw_arbiter dut (
    .clock(clock), .reset(reset),
    .req_0_valid(req_0_valid), .req_0_ready(req_0_ready), .req_0_wmode(req_0_wmode),
    .req_0_addr(req_0_addr), .req_0_wmask(req_0_wmask), .req_0_wdata(req_0_wdata),
    .resp_0_valid(resp_0_valid), .resp_0_ready(resp_0_ready), .resp_0_rdata(resp_0_rdata),
    .req_1_valid(req_1_valid), .req_1_ready(req_1_ready), .req_1_wmode(req_1_wmode),
    .req_1_addr(req_1_addr), .req_1_wmask(req_1_wmask), .req_1_wdata(req_1_wdata),
    .resp_1_valid(resp_1_valid), .resp_1_ready(resp_1_ready), .resp_1_rdata(resp_1_rdata),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM, starts with garbage so the zero-fill matters
  logic [63:0] sram_mem [256];
  initial for (int i = 0; i < 256; i++) sram_mem[i] <= {$urandom, $urandom};
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < 8; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: outstanding reads per requester, response queues with
  // the cycle at which each response becomes visible, and a memory image.
  typedef struct { int rdy; logic [63:0] d; } rsp_t;
  rsp_t        rq [2][$];
  rsp_t        m_tmp;
  logic [63:0] ref_mem [256];
  int          m_out [2];
  int          m_cyc = 0, m_ptr = 0, m_idx = 0, m_g;
  bit          m_live = 0, m_init = 1;
  logic        m_v[2], m_wm[2], m_rr[2], m_rdy[2], m_rv[2], m_e[2], m_ev;
  logic [7:0]  m_ad[2], m_mk[2];
  logic [63:0] m_wd[2], m_rd[2];

  always @(negedge clock) begin
    m_cyc++;
    m_v[0] = req_0_valid;   m_v[1] = req_1_valid;
    m_wm[0] = req_0_wmode;  m_wm[1] = req_1_wmode;
    m_ad[0] = req_0_addr;   m_ad[1] = req_1_addr;
    m_mk[0] = req_0_wmask;  m_mk[1] = req_1_wmask;
    m_wd[0] = req_0_wdata;  m_wd[1] = req_1_wdata;
    m_rr[0] = resp_0_ready; m_rr[1] = resp_1_ready;
    m_rdy[0] = req_0_ready; m_rdy[1] = req_1_ready;
    m_rv[0] = resp_0_valid; m_rv[1] = resp_1_valid;
    m_rd[0] = resp_0_rdata; m_rd[1] = resp_1_rdata;
    if (reset) begin
      m_live = 1; m_init = 1; m_idx = 0; m_ptr = 0;
      m_out[0] = 0; m_out[1] = 0;
      rq[0].delete(); rq[1].delete();
    end else if (m_live) begin
      if (m_init) begin
        chk("init_sram_en", sram_en, 1);
        chk("init_sram_wmode", sram_wmode, 1);
        chk("init_sram_addr", sram_addr, m_idx);
        chk("init_sram_wmask", sram_wmask, 8'hFF);
        chk("init_sram_wdata", sram_wdata, 0);
        chk("init_req_0_ready", m_rdy[0], 0);
        chk("init_req_1_ready", m_rdy[1], 0);
        chk("init_resp_0_valid", m_rv[0], 0);
        chk("init_resp_1_valid", m_rv[1], 0);
        chk("init_done_low", init_done, 0);
        ref_mem[m_idx] = 64'h0;
        if (m_idx == 255) m_init = 0;
        m_idx++;
      end else begin
        for (int n = 0; n < 2; n++) m_e[n] = m_v[n] && (m_wm[n] || m_out[n] < 2);
        m_g = -1;
        if (m_e[0] && m_e[1]) m_g = m_ptr;
        else if (m_e[0]) m_g = 0;
        else if (m_e[1]) m_g = 1;
        chk("init_done_high", init_done, 1);
        for (int n = 0; n < 2; n++) chk($sformatf("req_%0d_ready", n), m_rdy[n], m_g == n);
        chk("sram_en", sram_en, m_g >= 0);
        if (m_g >= 0) begin
          chk("sram_wmode", sram_wmode, m_wm[m_g]);
          chk("sram_addr", sram_addr, m_ad[m_g]);
          if (m_wm[m_g]) begin
            chk("sram_wmask", sram_wmask, m_mk[m_g]);
            chk("sram_wdata", sram_wdata, m_wd[m_g]);
          end
        end
        for (int n = 0; n < 2; n++) begin
          m_ev = (rq[n].size() > 0) && (rq[n][0].rdy <= m_cyc);
          chk($sformatf("resp_%0d_valid", n), m_rv[n], m_ev);
          if (m_ev) begin
            chk($sformatf("resp_%0d_rdata", n), m_rd[n], rq[n][0].d);
            if (m_rr[n]) begin
              void'(rq[n].pop_front());
              m_out[n]--;
            end
          end
        end
        if (m_g >= 0) begin
          if (!m_wm[m_g]) begin
            m_tmp.rdy = m_cyc + 2;
            m_tmp.d   = ref_mem[m_ad[m_g]];
            rq[m_g].push_back(m_tmp);
            m_out[m_g]++;
          end else begin
            for (int b = 0; b < 8; b++)
              if (m_mk[m_g][b]) ref_mem[m_ad[m_g]][8*b +: 8] = m_wd[m_g][8*b +: 8];
          end
          m_ptr = 1 - m_g;
        end
      end
    end
  end

  task automatic issue(input int n, input logic w, input logic [7:0] a,
                       input logic [7:0] m, input logic [63:0] d);
    int k = 0;
    logic r;
    if (n == 0) begin
      req_0_valid = 1; req_0_wmode = w; req_0_addr = a; req_0_wmask = m; req_0_wdata = d;
    end else begin
      req_1_valid = 1; req_1_wmode = w; req_1_addr = a; req_1_wmask = m; req_1_wdata = d;
    end
    do begin
      @(negedge clock);
      k++;
      r = (n == 0) ? req_0_ready : req_1_ready;
    end while (!r && k < 50);
    chk($sformatf("issue_grant_%0d", n), r, 1);
    @(posedge clock); #1;
    if (n == 0) req_0_valid = 0; else req_1_valid = 0;
  endtask

  task automatic wait_resp(input int n, input logic [63:0] exp, output int k);
    logic v;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      v = (n == 0) ? resp_0_valid : resp_1_valid;
    end while (!v && k < 20);
    chk($sformatf("lit_resp_%0d_valid", n), v, 1);
    chk($sformatf("lit_resp_%0d_rdata", n), (n == 0) ? resp_0_rdata : resp_1_rdata, exp);
    @(posedge clock); #1;
  endtask

  // Counts cycles from reset release until init_done; also counts any
  // resp_0_valid seen on the way.
  task automatic wait_init(input string name, output int nv);
    int k = 0;
    nv = 0;
    do begin
      @(negedge clock);
      k++;
      if (resp_0_valid) nv++;
    end while (!init_done && k < 400);
    chk(name, k, 257);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nv, g0, g1;
    reset = 1;
    req_0_valid = 0; req_0_wmode = 0; req_0_addr = 0; req_0_wmask = 0; req_0_wdata = 0;
    req_1_valid = 0; req_1_wmode = 0; req_1_addr = 0; req_1_wmask = 0; req_1_wdata = 0;
    resp_0_ready = 1; resp_1_ready = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    wait_init("init_latency", nv);
    @(posedge clock); #1;

    // Both requesters hold reads: grants alternate starting with 0
    req_0_valid = 1; req_0_wmode = 0; req_0_addr = 8'h03;
    req_1_valid = 1; req_1_wmode = 0; req_1_addr = 8'h04;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("alt_grant_0", req_0_ready, (i % 2) == 0);
      chk("alt_grant_1", req_1_ready, (i % 2) == 1);
      @(posedge clock); #1;
    end
    req_0_valid = 0; req_1_valid = 0;
    repeat (4) @(posedge clock); #1;

    // Masked write then read back
    issue(0, 1, 8'h10, 8'h0F, 64'h1122334455667788);
    issue(0, 0, 8'h10, 8'hFF, 64'h0);
    wait_resp(0, 64'h0000000055667788, k);
    chk("read_latency", k, 2);

    // Pointer is 1: same-cycle read (req1) wins over write (req0), sees old data
    req_0_valid = 1; req_0_wmode = 1; req_0_addr = 8'h20; req_0_wmask = 8'hFF;
    req_0_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    req_1_valid = 1; req_1_wmode = 0; req_1_addr = 8'h20;
    @(negedge clock);
    chk("order_rd_first", req_1_ready, 1);
    chk("order_wr_waits", req_0_ready, 0);
    @(posedge clock); #1 req_1_valid = 0;
    @(negedge clock);
    chk("order_wr_next", req_0_ready, 1);
    @(posedge clock); #1 req_0_valid = 0;
    wait_resp(1, 64'h0, k);
    issue(1, 0, 8'h20, 8'hFF, 64'h0);
    wait_resp(1, 64'hAAAA_AAAA_AAAA_AAAA, k);

    // Back-pressure on requester 1 while requester 0 keeps writing
    resp_1_ready = 0;
    req_0_valid = 1; req_0_wmode = 1; req_0_addr = 8'h30; req_0_wmask = 8'h3C;
    req_0_wdata = 64'h0123_4567_89AB_CDEF;
    req_1_valid = 1; req_1_wmode = 0; req_1_addr = 8'h10;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      g0 += int'(req_0_ready);
      g1 += int'(req_1_ready);
      @(posedge clock); #1;
    end
    chk("bp_grants_1", g1, 2);
    chk("bp_grants_0", g0, 10);
    resp_1_ready = 1;
    k = 0;
    do begin @(negedge clock); k++; end while (!req_1_ready && k < 10);
    chk("bp_resume", req_1_ready, 1);
    @(posedge clock); #1 req_0_valid = 0; req_1_valid = 0;
    repeat (8) @(posedge clock); #1;

    // Reset with one response queued and one read in flight
    resp_0_ready = 0;
    issue(0, 0, 8'h10, 8'hFF, 64'h0);
    issue(0, 0, 8'h11, 8'hFF, 64'h0);
    reset = 1;
    @(posedge clock); #1 reset = 0;
    wait_init("reinit_latency", nv);
    chk("reset_no_resp", nv, 0);
    @(posedge clock); #1;
    req_0_valid = 1; req_0_wmode = 0; req_0_addr = 8'h01;
    req_1_valid = 1; req_1_wmode = 0; req_1_addr = 8'h02;
    @(negedge clock);
    chk("reset_ptr_0", req_0_ready, 1);
    chk("reset_ptr_1", req_1_ready, 0);
    @(posedge clock); #1 req_0_valid = 0; req_1_valid = 0; resp_0_ready = 1;
    repeat (4) @(posedge clock); #1;

    // Randomized traffic with one reset in the middle
    for (int it = 0; it < 3000; it++) begin
      req_0_valid  = ($urandom_range(0, 9) < 6);
      req_0_wmode  = $urandom_range(0, 1);
      req_0_addr   = 8'($urandom_range(0, 15));
      req_0_wmask  = 8'($urandom);
      req_0_wdata  = {$urandom, $urandom};
      req_1_valid  = ($urandom_range(0, 9) < 6);
      req_1_wmode  = $urandom_range(0, 1);
      req_1_addr   = 8'($urandom_range(0, 15));
      req_1_wmask  = 8'($urandom);
      req_1_wdata  = {$urandom, $urandom};
      resp_0_ready = ($urandom_range(0, 9) < 7);
      resp_1_ready = ($urandom_range(0, 9) < 7);
      reset        = (it == 1500);
      @(posedge clock); #1;
    end
    req_0_valid = 0; req_1_valid = 0; resp_0_ready = 1; resp_1_ready = 1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
